membrane_accumulator: RTL and testbench

- Clocked stage directly upstream of the spike/residue threshold stage in the PE.
- Accumulates NUM_PSUM unsigned partial sums per timestep onto the residue left from the previous timestep, and hands the resulting membrane potential downstream.
- Takes back the residue the threshold stage returns and uses it as the start value of the next timestep.
- Clears the residue after NUM_TIMESTEPS timesteps, which starts a new inference.

---
 rtl/membrane_accumulator.sv | 146 ++++++++++++++
 tb/tb_membrane_accumulator.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/membrane_accumulator.sv
// Membrane potential accumulator: sums NUM_PSUM partial sums per timestep on
// top of the residue returned by the threshold stage, hands the potential
// downstream and takes the new residue back. The residue is cleared after
// NUM_TIMESTEPS timesteps, which starts a new inference.
module membrane_accumulator #(
    parameter int WIDTH         = 8,
    parameter int PSUM_WIDTH    = 8,
    parameter int NUM_PSUM      = 3,
    parameter int NUM_TIMESTEPS = 2,
    parameter int TS_W          = (NUM_TIMESTEPS > 1) ? $clog2(NUM_TIMESTEPS) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PSUM_WIDTH-1:0] psum_data,
    input  logic                  psum_valid,
    output logic                  psum_ready,
    output logic [WIDTH-1:0]      pot_data,
    output logic                  pot_valid,
    input  logic                  pot_ready,
    output logic                  pot_sat,
    input  logic [WIDTH-1:0]      res_data,
    input  logic                  res_valid,
    output logic                  res_ready,
    output logic [TS_W-1:0]       timestep,
    output logic                  done
);

    localparam int CNT_W = (NUM_PSUM > 1) ? $clog2(NUM_PSUM + 1) : 1;

    typedef enum logic [1:0] {
        ST_ACCUM    = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RES = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_next_s;
    // The accumulator doubles as the residue register: the returned residue is
    // loaded straight into it as the start value of the next timestep.
    logic [WIDTH-1:0]   acc_r;
    logic [CNT_W-1:0]   count_r;
    logic [TS_W-1:0]    ts_r;
    logic               sat_r;
    logic               done_r;

    logic [WIDTH:0]     sum_s;
    logic               last_psum_s;
    logic               last_ts_s;

    assign sum_s       = {1'b0, acc_r} + (WIDTH + 1)'(psum_data);
    assign last_psum_s = (count_r == CNT_W'(NUM_PSUM - 1));
    assign last_ts_s   = (ts_r == TS_W'(NUM_TIMESTEPS - 1));

    // Handshake flags decode directly from the state register (glitch-free).
    assign psum_ready = (state_r == ST_ACCUM);
    assign pot_valid  = (state_r == ST_SEND);
    assign res_ready  = (state_r == ST_WAIT_RES);
    assign pot_data   = acc_r;
    assign pot_sat    = sat_r;
    assign timestep   = ts_r;
    assign done       = done_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_ACCUM;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: each state opens exactly one input channel.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (psum_valid && last_psum_s) begin
                    state_next_s = ST_SEND;
                end else begin
                    state_next_s = ST_ACCUM;
                end
            end
            ST_SEND: begin
                if (pot_ready) begin
                    state_next_s = ST_WAIT_RES;
                end else begin
                    state_next_s = ST_SEND;
                end
            end
            ST_WAIT_RES: begin
                if (res_valid) begin
                    state_next_s = ST_ACCUM;
                end else begin
                    state_next_s = ST_WAIT_RES;
                end
            end
            default: begin
                state_next_s = ST_ACCUM;
            end
        endcase
    end

    // Datapath: saturating accumulate, residue reload, timestep and done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= {WIDTH{1'b0}};
            count_r <= {CNT_W{1'b0}};
            ts_r    <= {TS_W{1'b0}};
            sat_r   <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_ACCUM: begin
                    if (psum_valid) begin
                        count_r <= count_r + CNT_W'(1);
                        if (sum_s[WIDTH]) begin
                            acc_r <= {WIDTH{1'b1}};
                            sat_r <= 1'b1;
                        end else begin
                            acc_r <= sum_s[WIDTH-1:0];
                        end
                    end
                end
                ST_WAIT_RES: begin
                    if (res_valid) begin
                        count_r <= {CNT_W{1'b0}};
                        sat_r   <= 1'b0;
                        if (!last_ts_s) begin
                            acc_r <= res_data;
                            ts_r  <= ts_r + TS_W'(1);
                        end else begin
                            acc_r  <= {WIDTH{1'b0}};
                            ts_r   <= {TS_W{1'b0}};
                            done_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    acc_r <= acc_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_membrane_accumulator.sv
// Directed self-checking bench for membrane_accumulator (WIDTH=8, NUM_PSUM=3,
// NUM_TIMESTEPS=2). The bench plays the threshold stage with threshold 64;
// residues are hand-computed. Inputs change 1 ns after the rising edge and
// outputs are sampled there too, well away from the next active edge.
module tb_membrane_accumulator;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] psum_data;
    logic       psum_valid;
    logic       psum_ready;
    logic [7:0] pot_data;
    logic       pot_valid;
    logic       pot_ready;
    logic       pot_sat;
    logic [7:0] res_data;
    logic       res_valid;
    logic       res_ready;
    logic [0:0] timestep;
    logic       done;

    int n_cmp = 0;
    int n_bad = 0;

    localparam int LIMIT = 20;

    membrane_accumulator #(
        .WIDTH(8), .PSUM_WIDTH(8), .NUM_PSUM(3), .NUM_TIMESTEPS(2)
    ) dut (
        .clk(clk), .rst(rst),
        .psum_data(psum_data), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .pot_data(pot_data), .pot_valid(pot_valid), .pot_ready(pot_ready),
        .pot_sat(pot_sat),
        .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
        .timestep(timestep), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One psum transfer; returns 1 ns after the accepting edge.
    task automatic send_psum(input logic [7:0] d);
        int n = 0;
        psum_data  = d;
        psum_valid = 1'b1;
        while (!psum_ready && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) check_eq("psum_ready_timeout", 0, 1);
        step();
        psum_valid = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        send_psum(a);
        send_psum(b);
        send_psum(c);
    endtask

    // Check the presented potential, then take it with a one-cycle pot_ready.
    task automatic recv_pot(input string tag, input int exp_data, input int exp_sat);
        int n = 0;
        while (!pot_valid && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) check_eq({tag, "_pot_timeout"}, 0, 1);
        check_eq({tag, "_pot_data"}, pot_data, exp_data);
        check_eq({tag, "_pot_sat"}, pot_sat, exp_sat);
        pot_ready = 1'b1;
        step();
        pot_ready = 1'b0;
        check_eq({tag, "_pot_valid_fall"}, pot_valid, 0);
    endtask

    // Return a residue; checks timestep and done right after the transfer.
    task automatic send_res(input string tag, input logic [7:0] d, input int exp_ts,
                            input int exp_done);
        int n = 0;
        res_data  = d;
        res_valid = 1'b1;
        while (!res_ready && n < LIMIT) begin
            step();
            n++;
        end
        if (n >= LIMIT) check_eq({tag, "_res_timeout"}, 0, 1);
        step();
        res_valid = 1'b0;
        check_eq({tag, "_timestep"}, timestep, exp_ts);
        check_eq({tag, "_done"}, done, exp_done);
        step();
        check_eq({tag, "_done_after"}, done, 0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_pot_valid"}, pot_valid, 0);
        check_eq({tag, "_res_ready"}, res_ready, 0);
        check_eq({tag, "_done"}, done, 0);
        check_eq({tag, "_pot_data"}, pot_data, 0);
        check_eq({tag, "_pot_sat"}, pot_sat, 0);
        check_eq({tag, "_timestep"}, timestep, 0);
    endtask

    initial begin
        rst        = 1'b1;
        psum_data  = 8'd0;
        psum_valid = 1'b0;
        pot_ready  = 1'b0;
        res_data   = 8'd0;
        res_valid  = 1'b0;

        // Reset state
        step();
        step();
        check_reset_outputs("rst");
        rst = 1'b0;
        step();
        check_eq("rst_psum_ready", psum_ready, 1);

        // Basic: 10+20+30 = 60, below threshold -> residue 60
        send3(8'd10, 8'd20, 8'd30);
        check_eq("basic_latency_pot_valid", pot_valid, 1);
        check_eq("basic_psum_ready_low", psum_ready, 0);
        recv_pot("basic", 60, 0);
        check_eq("basic_res_ready", res_ready, 1);
        send_res("basic", 8'd60, 1, 0);

        // Second timestep: 60+15 = 75 -> residue 11, end of inference
        send3(8'd5, 8'd5, 8'd5);
        recv_pot("ts1", 75, 0);
        send_res("ts1", 8'd11, 0, 1);

        // New inference starts from zero: 3
        send3(8'd1, 8'd1, 8'd1);
        recv_pot("clr", 3, 0);
        send_res("clr", 8'd3, 1, 0);
        send3(8'd0, 8'd0, 8'd0);
        recv_pot("clr_ts1", 3, 0);
        send_res("clr_ts1", 8'd3, 0, 1);

        // Saturation at ts0: 200+100 clips to 255, +50 stays 255
        send3(8'd200, 8'd100, 8'd50);
        recv_pot("sat", 255, 1);
        send_res("sat", 8'd191, 1, 0);
        send3(8'd1, 8'd1, 8'd1);
        recv_pot("sat_next", 194, 0);
        send_res("sat_next", 8'd130, 0, 1);

        // Bubbles and backpressure: 7+8+9 = 24
        send_psum(8'd7);
        step();
        step();
        check_eq("bub_psum_ready", psum_ready, 1);
        check_eq("bub_pot_valid", pot_valid, 0);
        send_psum(8'd8);
        step();
        step();
        send_psum(8'd9);
        psum_data  = 8'd77;
        psum_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_pot_valid", pot_valid, 1);
            check_eq("bp_pot_data", pot_data, 24);
            check_eq("bp_psum_ready", psum_ready, 0);
            step();
        end
        psum_valid = 1'b0;
        recv_pot("bp", 24, 0);
        send_res("bp", 8'd24, 1, 0);
        send3(8'd0, 8'd0, 8'd0);
        recv_pot("bp_ts1", 24, 0);
        send_res("bp_ts1", 8'd24, 0, 1);

        // Stray residue during ACCUM is ignored
        res_data  = 8'd99;
        res_valid = 1'b1;
        step();
        check_eq("stray_res_ready", res_ready, 0);
        send3(8'd1, 8'd2, 8'd3);
        res_valid = 1'b0;
        recv_pot("stray", 6, 0);
        send_res("stray", 8'd6, 1, 0);

        // Reset mid-operation at timestep 1 after two psums
        send_psum(8'd1);
        send_psum(8'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("mid_rst");
        step();
        check_eq("mid_rst_psum_ready", psum_ready, 1);
        send3(8'd1, 8'd2, 8'd3);
        recv_pot("mid_rst", 6, 0);
        send_res("mid_rst", 8'd6, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
